// File: rtl/uart_pkg.sv
// Shared types and constants for the parametrised UART receiver.
// Holds the state encoding, parity mode codes and the frame-length helper.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_DONE,
    ST_WAIT_IDLE
  } rx_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // Bits per frame: start + data + optional parity + stop bits.
  function automatic int frame_bits(input int data_w, input int parity, input int stop_bits);
    return 1 + data_w + ((parity != PAR_NONE) ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous rxd pad, resetting to the idle level.
// Latency 2 clk; no flow control.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic rxd,
  output logic rxd_s
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta  <= 1'b1;
      rxd_s <= 1'b1;
    end else begin
      meta  <= rxd;
      rxd_s <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: rxd -> DATA_W word, 3-sample majority per bit, parity/framing flags.
// Word valid H+2+(N-1)*CLKS_PER_BIT clks after start detect; held until rx_ready, a frame completing while full is dropped with an overrun pulse.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 15,
  parameter int PARITY       = PAR_NONE,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_en,
  input  logic              rxd,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun,
  output logic              busy
);

  localparam int N  = frame_bits(DATA_W, PARITY, STOP_BITS);
  localparam int H  = CLKS_PER_BIT / 2;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int KW = $clog2(N);

  logic              rxd_s;
  rx_state_t         state, state_nxt;
  logic [CW-1:0]     cnt;
  logic [KW-1:0]     bit_k;
  logic              s0, s1;
  logic [DATA_W-1:0] shreg;
  logic              par_acc;
  logic              par_bad;
  logic              stop_bad;
  logic              bit_dec;
  logic              bit_val;
  logic              deliver;

  uart_rx_sync u_sync (
    .clk   (clk),
    .rst   (rst),
    .rxd   (rxd),
    .rxd_s (rxd_s)
  );

  assign busy = (state != ST_IDLE);

  always_comb begin
    state_nxt = state;
    bit_dec   = 1'b0;
    deliver   = 1'b0;
    // Third sample is the live rxd_s on the decision edge.
    bit_val   = (s0 & s1) | (s0 & rxd_s) | (s1 & rxd_s);
    if (state inside {ST_START, ST_DATA, ST_PARITY, ST_STOP})
      bit_dec = (cnt == CW'(H));

    case (state)
      ST_IDLE:      if (!rxd_s) state_nxt = ST_START;
      ST_START:     if (bit_dec) state_nxt = bit_val ? ST_IDLE : ST_DATA;
      ST_DATA:      if (bit_dec && bit_k == KW'(DATA_W))
                      state_nxt = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
      ST_PARITY:    if (bit_dec) state_nxt = ST_STOP;
      ST_STOP:      if (bit_dec && bit_k == KW'(N - 1)) state_nxt = ST_DONE;
      ST_DONE: begin
        deliver   = 1'b1;
        state_nxt = rxd_s ? ST_IDLE : ST_WAIT_IDLE;
      end
      ST_WAIT_IDLE: if (rxd_s) state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase

    // Disabling the receiver abandons whatever frame is in flight.
    if (!rx_en) begin
      state_nxt = ST_IDLE;
      deliver   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      bit_k      <= '0;
      s0         <= 1'b1;
      s1         <= 1'b1;
      shreg      <= '0;
      par_acc    <= 1'b0;
      par_bad    <= 1'b0;
      stop_bad   <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state   <= state_nxt;
      overrun <= 1'b0;

      if (state == ST_IDLE) begin
        cnt      <= '0;
        bit_k    <= '0;
        par_acc  <= 1'b0;
        par_bad  <= 1'b0;
        stop_bad <= 1'b0;
      end else begin
        cnt <= (cnt == CW'(CLKS_PER_BIT - 1)) ? '0 : cnt + 1'b1;
        if (cnt == CW'(H - 2)) s0 <= rxd_s;
        if (cnt == CW'(H - 1)) s1 <= rxd_s;
        if (bit_dec) begin
          bit_k <= bit_k + 1'b1;
          case (state)
            ST_DATA: begin
              shreg   <= {bit_val, shreg[DATA_W-1:1]};
              par_acc <= par_acc ^ bit_val;
            end
            ST_PARITY: par_bad <= bit_val != ((PARITY == PAR_ODD) ? ~par_acc : par_acc);
            ST_STOP:   if (!bit_val) stop_bad <= 1'b1;
            default: ;
          endcase
        end
      end

      // A transfer on the delivery edge frees the slot for the new word.
      if (deliver) begin
        if (!rx_valid || rx_ready) begin
          rx_data    <= shreg;
          parity_err <= par_bad;
          frame_err  <= stop_bad;
          rx_valid   <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: three instances (no/even/odd parity) checked every cycle
// against a waveform-sampling frame model, plus literal checks on key events.
module tb_uart_rx_param;

  localparam int CPB = 15;
  localparam int H   = CPB / 2;

  logic clk;
  logic rst;
  logic rx_en;
  logic rx_ready;
  logic rxd0;
  logic rxd_p;

  logic [7:0] o_data [3];
  logic [2:0] o_vld, o_pe, o_fe, o_ov, o_busy;

  uart_rx_param #(.DATA_W(8), .CLKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(1)) dut0 (
    .clk(clk), .rst(rst), .rx_en(rx_en), .rxd(rxd0),
    .rx_data(o_data[0]), .rx_valid(o_vld[0]), .rx_ready(rx_ready),
    .parity_err(o_pe[0]), .frame_err(o_fe[0]), .overrun(o_ov[0]), .busy(o_busy[0])
  );

  uart_rx_param #(.DATA_W(8), .CLKS_PER_BIT(CPB), .PARITY(1), .STOP_BITS(1)) dut1 (
    .clk(clk), .rst(rst), .rx_en(rx_en), .rxd(rxd_p),
    .rx_data(o_data[1]), .rx_valid(o_vld[1]), .rx_ready(rx_ready),
    .parity_err(o_pe[1]), .frame_err(o_fe[1]), .overrun(o_ov[1]), .busy(o_busy[1])
  );

  uart_rx_param #(.DATA_W(8), .CLKS_PER_BIT(CPB), .PARITY(2), .STOP_BITS(1)) dut2 (
    .clk(clk), .rst(rst), .rx_en(rx_en), .rxd(rxd_p),
    .rx_data(o_data[2]), .rx_valid(o_vld[2]), .rx_ready(rx_ready),
    .parity_err(o_pe[2]), .frame_err(o_fe[2]), .overrun(o_ov[2]), .busy(o_busy[2])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- model: instance i has parity mode i ----------------
  bit         ms1 [3];
  bit         ms  [3];
  bit         act [3];
  bit         wt  [3];
  bit         mv  [3];
  bit         mpe [3];
  bit         mfe [3];
  bit         mov [3];
  logic [7:0] md  [3];
  int         t0  [3];
  bit         hist [3][512];
  int         mc = 0;
  bit         mstart = 1'b0;

  function automatic bit vote(input int i, input int t);
    bit a, b, c;
    a = hist[i][(t - 1) & 511];
    b = hist[i][t & 511];
    c = hist[i][(t + 1) & 511];
    return (a & b) | (a & c) | (b & c);
  endfunction

  always @(posedge clk) begin
    bit sv, dlv, pe, fe, px;
    logic [7:0] w;
    int nb, nf;
    w = '0;
    pe = 1'b0;
    fe = 1'b0;
    for (int i = 0; i < 3; i++) begin
      nf = (i == 0) ? 10 : 11;
      if (rst) begin
        ms1[i] = 1'b1; ms[i] = 1'b1; act[i] = 1'b0; wt[i] = 1'b0;
        mv[i] = 1'b0; md[i] = '0; mpe[i] = 1'b0; mfe[i] = 1'b0; mov[i] = 1'b0;
      end else begin
        sv = ms[i];
        hist[i][mc & 511] = sv;
        mov[i] = 1'b0;
        dlv = 1'b0;
        if (act[i]) begin
          if (!rx_en) act[i] = 1'b0;
          else if (mc == t0[i] + H + 1) begin
            if (vote(i, t0[i] + H)) act[i] = 1'b0;
          end else if (mc == t0[i] + H + 2 + (nf - 1) * CPB) begin
            for (int k = 1; k <= 8; k++) w[k-1] = vote(i, t0[i] + H + k * CPB);
            pe = 1'b0;
            nb = 9;
            if (i != 0) begin
              px = (i == 1) ? ^w : ~^w;
              pe = (vote(i, t0[i] + H + 9 * CPB) != px);
              nb = 10;
            end
            fe = 1'b0;
            for (int k = nb; k < nf; k++) if (!vote(i, t0[i] + H + k * CPB)) fe = 1'b1;
            dlv = 1'b1;
            act[i] = 1'b0;
            wt[i] = !sv;
          end
        end else if (wt[i]) begin
          if (!rx_en || sv) wt[i] = 1'b0;
        end else if (rx_en && !sv) begin
          act[i] = 1'b1;
          t0[i] = mc;
        end
        if (dlv) begin
          if (!mv[i] || rx_ready) begin
            mv[i] = 1'b1; md[i] = w; mpe[i] = pe; mfe[i] = fe;
          end else begin
            mov[i] = 1'b1;
          end
        end else if (mv[i] && rx_ready) begin
          mv[i] = 1'b0;
        end
        ms[i] = ms1[i];
        ms1[i] = (i == 0) ? rxd0 : rxd_p;
      end
    end
    mc = mc + 1;
    mstart = 1'b1;
  end

  // ---------------- checking and stimulus ----------------
  int vecs = 0;
  int errs = 0;
  int rise_cyc = 0;
  bit prev_vld0 = 1'b0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic drive(input int line, input logic v);
    if (line == 0) rxd0 = v;
    else rxd_p = v;
  endtask

  // Leaves the line at the stop-bit level; g selects a frame bit that gets a 1-clk inversion.
  task automatic send_frame(input int line, input logic [7:0] d, input int pbit,
                            input logic stop_v, input int g);
    logic [10:0] bits;
    int n;
    bits = '0;
    n = 1;
    for (int i = 0; i < 8; i++) begin bits[n] = d[i]; n++; end
    if (pbit >= 0) begin bits[n] = pbit[0]; n++; end
    bits[n] = stop_v;
    n++;
    for (int k = 0; k < n; k++) begin
      drive(line, bits[k]);
      if (k == g) begin
        repeat (7) @(negedge clk);
        drive(line, ~bits[k]);
        @(negedge clk);
        drive(line, bits[k]);
        repeat (7) @(negedge clk);
      end else begin
        repeat (CPB) @(negedge clk);
      end
    end
  endtask

  task automatic accept();
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  initial begin
    int st;
    rst = 1'b1; rx_en = 1'b1; rx_ready = 1'b0; rxd0 = 1'b1; rxd_p = 1'b1;

    fork
      forever begin
        @(negedge clk);
        if (mstart) begin
          for (int i = 0; i < 3; i++) begin
            vecs++;
            if (o_vld[i] !== mv[i] || o_data[i] !== md[i] || o_pe[i] !== mpe[i] ||
                o_fe[i] !== mfe[i] || o_ov[i] !== mov[i] || o_busy[i] !== (act[i] | wt[i])) begin
              errs++;
              $display("FAIL model cyc%0d dut%0d vld/data/pe/fe/ov/busy got %b/%h/%b/%b/%b/%b want %b/%h/%b/%b/%b/%b",
                       mc, i, o_vld[i], o_data[i], o_pe[i], o_fe[i], o_ov[i], o_busy[i],
                       mv[i], md[i], mpe[i], mfe[i], mov[i], act[i] | wt[i]);
            end
          end
          if (o_vld[0] && !prev_vld0) rise_cyc = mc;
          prev_vld0 = o_vld[0];
        end
      end
    join_none

    repeat (3) @(negedge clk);
    chk("rst_valid", o_vld[0], 0);
    chk("rst_data", o_data[0], 0);
    chk("rst_perr", o_pe[0], 0);
    chk("rst_ferr", o_fe[0], 0);
    chk("rst_ovr", o_ov[0], 0);
    chk("rst_busy", o_busy[0], 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Basic frame, latency and release on transfer
    st = mc;
    send_frame(0, 8'h55, -1, 1'b1, -1);
    chk("lat55", rise_cyc - st, 147);
    chk("data55", o_data[0], 8'h55);
    chk("perr55", o_pe[0], 0);
    chk("ferr55", o_fe[0], 0);
    accept();
    chk("clr55", o_vld[0], 0);

    // Parity: same bits into even and odd receivers
    send_frame(1, 8'hA3, 1, 1'b1, -1);
    chk("even_p1_data", o_data[1], 8'hA3);
    chk("even_p1_perr", o_pe[1], 1);
    chk("odd_p1_data", o_data[2], 8'hA3);
    chk("odd_p1_perr", o_pe[2], 0);
    accept();
    send_frame(1, 8'hA3, 0, 1'b1, -1);
    chk("even_p0_perr", o_pe[1], 0);
    chk("odd_p0_perr", o_pe[2], 1);
    accept();

    // Short low pulse in idle is a false start
    drive(0, 1'b0);
    repeat (4) @(negedge clk);
    drive(0, 1'b1);
    chk("glitch_busy", o_busy[0], 1);
    repeat (20) @(negedge clk);
    chk("glitch_idle", o_busy[0], 0);
    chk("glitch_novld", o_vld[0], 0);

    // One-clock inversion inside data bit 2 is outvoted
    send_frame(0, 8'h3C, -1, 1'b1, 3);
    chk("vote_data", o_data[0], 8'h3C);
    chk("vote_vld", o_vld[0], 1);
    accept();

    // Stop bit low followed by a break
    send_frame(0, 8'h0F, -1, 1'b0, -1);
    chk("brk_data", o_data[0], 8'h0F);
    chk("brk_ferr", o_fe[0], 1);
    accept();
    repeat (45) @(negedge clk);
    chk("brk_wait_busy", o_busy[0], 1);
    chk("brk_no_retrig", o_vld[0], 0);
    drive(0, 1'b1);
    repeat (5) @(negedge clk);
    chk("brk_release", o_busy[0], 0);

    // Back-to-back with consumer stalled: overrun, held word kept
    send_frame(0, 8'h11, -1, 1'b1, -1);
    fork
      send_frame(0, 8'h22, -1, 1'b1, -1);
      begin
        repeat (147) @(negedge clk);
        chk("ovr_pulse", o_ov[0], 1);
        chk("ovr_keep", o_data[0], 8'h11);
        @(negedge clk);
        chk("ovr_one_cycle", o_ov[0], 0);
      end
    join
    accept();

    // Back-to-back with a transfer on the delivery edge
    send_frame(0, 8'h11, -1, 1'b1, -1);
    fork
      send_frame(0, 8'h22, -1, 1'b1, -1);
      begin
        repeat (146) @(negedge clk);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        chk("swap_vld", o_vld[0], 1);
        chk("swap_data", o_data[0], 8'h22);
        chk("swap_noovr", o_ov[0], 0);
      end
    join
    accept();

    // Receiver disabled during data bit 3
    fork
      send_frame(0, 8'h5A, -1, 1'b1, -1);
      begin
        repeat (67) @(negedge clk);
        rx_en = 1'b0;
        @(negedge clk);
        chk("en_abort_busy", o_busy[0], 0);
        repeat (99) @(negedge clk);
        rx_en = 1'b1;
      end
    join
    chk("en_no_word", o_vld[0], 0);

    // Reset during data bit 5 with a word held
    send_frame(0, 8'h5A, -1, 1'b1, -1);
    chk("pre_rst_held", o_vld[0], 1);
    fork
      send_frame(0, 8'hE0, -1, 1'b1, -1);
      begin
        repeat (97) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_vld", o_vld[0], 0);
        chk("rst_mid_data", o_data[0], 0);
        chk("rst_mid_busy", o_busy[0], 0);
      end
    join
    chk("rst_no_word", o_vld[0], 0);

    // Recovery frame
    send_frame(0, 8'h81, -1, 1'b1, -1);
    chk("rec_vld", o_vld[0], 1);
    chk("rec_data", o_data[0], 8'h81);
    chk("rec_ferr", o_fe[0], 0);
    accept();
    repeat (5) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
